nand_gate_array_cycle_delay: RTL and testbench
==============================================

// Module: nand_gate_array_cycle_delay
// PURPOSE
//  Parametrised array of CHANNELS independent INPUTS-input NAND gates with
//  synthesisable, clock-counted propagation delay replacing the simulation-only #DELAY.
//  Selectable transport (delay line) or inertial (pulse-rejecting) delay model.
//  Sits in the 74LSXX library as the generic clocked gate used by the clock IP's
//  decode/compare logic when real gate timing must be emulated on FPGA.
// PARAMETERS
//  CHANNELS   4  number of independent NAND gates
//  INPUTS     8  inputs per gate (legal 2..32)
//  DELAY_CYC  3  propagation delay in clk cycles (legal 1..255; 0 is an elaboration error)
//  INERTIAL   0  0 = transport delay, 1 = inertial delay
// PORTS
//  clk     in   1                 system clock, all state on rising edge
//  rst     in   1                 asynchronous, active-high reset
//  in_bus  in   CHANNELS*INPUTS   gate c inputs = in_bus[c*INPUTS +: INPUTS]; synchronous to clk
//  y       out  CHANNELS          delayed NAND outputs, registered
//  busy    out  CHANNELS          1 = channel c has a change in flight (y[c] not yet settled)
// BEHAVIOUR
//  - raw[c] = ~&in_bus[c*INPUTS +: INPUTS], combinational, sampled only at clk edges.
//  - Reset (async, takes effect without clk): y = all 1, delay lines all 1, counters 0,
//    busy = 0. Held while rst=1; first update on first rising edge after release.
//  - No input synchroniser; glitches between edges are invisible by design.
//  Transport (INERTIAL=0):
//  - Per channel shift register of DELAY_CYC stages; stage0 <= raw each edge.
//  - y[c] = last stage: raw sampled at edge n appears on y after edge n+DELAY_CYC-1
//    (visible DELAY_CYC edges after the input change, counting the sampling edge).
//  - Every pulse of >=1 cycle reproduced exactly, width preserved.
//  - busy[c] = 1 when any stage differs from y[c] (combinational from registers).
//  Inertial (INERTIAL=1), per-channel counter cnt, width $clog2(DELAY_CYC+1):
//  - States: SETTLED (cnt==0), PENDING (cnt!=0). Each edge:
//    raw==y          -> cnt<=0 (pending change cancelled)
//    raw!=y, cnt<DELAY_CYC-1 -> cnt<=cnt+1
//    raw!=y, cnt==DELAY_CYC-1 -> y<=raw, cnt<=0
//  - y changes on the DELAY_CYC-th consecutive edge sampling a mismatch; steady-change
//    latency equals transport mode. Mismatch lasting < DELAY_CYC edges is swallowed.
//  - DELAY_CYC=1: y follows raw one edge late, never PENDING.
//  - busy[c] = (cnt!=0).
//  - Counter never exceeds DELAY_CYC-1; no wrap.
//  Both modes:
//  - Channels fully independent; simultaneous changes on several channels allowed.
//  - Reset mid-operation discards all in-flight changes; nothing replays after release.
// TESTING  (CHANNELS=4, INPUTS=8, DELAY_CYC=3 unless stated)
//  1 Reset: rst=1 with in_bus=all 1, no clk edges -> y=4'hF, busy=0 immediately.
//  2 Transport: ch0 inputs 8'hFF sampled at edge 0 -> y[0]=0 after edge 2, busy[0]=1
//    edges 0-1; 1-cycle 8'hFF pulse -> 1-cycle low on y[0] after edge 2.
//  3 Inertial: ch0 8'hFF for 2 edges then 8'hFE -> y[0] stays 1, busy[0] 1 then 0;
//    8'hFF held 3 edges -> y[0]=0 after 3rd edge, busy[0]=0.
//  4 Independence: toggle ch2 every cycle, ch1 steady 8'hFF -> ch1 timing as 2/3,
//    ch2 in inertial mode y[2] never changes, busy[2] toggles.
//  5 Reset mid-count: inertial ch0 cnt=2, assert rst -> y=1, busy=0; release, hold
//    8'hFF -> y[0]=0 after 3 more edges (count restarted).
//  6 Each of the 8 inputs alone at 0, rest 1 -> y[c]=1; all 1 -> y[c]=0; sweep all c.

Source files
------------

// File: rtl/nand_gate_array_cycle_delay.sv
// Array of CHANNELS independent INPUTS-input NAND gates with a clock-counted
// propagation delay, either transport (delay line) or inertial (pulse rejecting).
module nand_gate_array_cycle_delay #(
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned INPUTS    = 8,
   parameter int unsigned DELAY_CYC = 3,
   parameter int unsigned INERTIAL  = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*INPUTS-1:0]   in_bus,
   output logic [CHANNELS-1:0]          y,
   output logic [CHANNELS-1:0]          busy
);

   if (DELAY_CYC < 1 || DELAY_CYC > 255) begin : g_bad_delay
      $error("nand_gate_array_cycle_delay: DELAY_CYC must be 1..255");
   end
   if (INPUTS < 2 || INPUTS > 32) begin : g_bad_inputs
      $error("nand_gate_array_cycle_delay: INPUTS must be 2..32");
   end

   logic [CHANNELS-1:0] raw;

   always_comb begin
      raw = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         raw[c] = ~&in_bus[c*INPUTS +: INPUTS];
      end
   end

   if (INERTIAL == 0) begin : g_transport
      // Bit 0 is the sampling stage, the MSB is the visible output stage.
      logic [CHANNELS-1:0][DELAY_CYC-1:0] line_q, line_d;

      always_comb begin
         line_d = line_q;
         y      = '0;
         busy   = '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            line_d[c] = (line_q[c] << 1) | DELAY_CYC'(raw[c]);
            y[c]      = line_q[c][DELAY_CYC-1];
            busy[c]   = |(line_q[c] ^ {DELAY_CYC{line_q[c][DELAY_CYC-1]}});
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            line_q <= '1;
         end else begin
            line_q <= line_d;
         end
      end
   end else begin : g_inertial
      localparam int unsigned    CW      = $clog2(DELAY_CYC + 1);
      localparam logic [CW-1:0]  CNT_MAX = CW'(DELAY_CYC - 1);

      logic [CHANNELS-1:0]          y_q, y_d;
      logic [CHANNELS-1:0][CW-1:0]  cnt_q, cnt_d;

      // cnt counts consecutive edges that sampled raw != y; a match cancels it.
      always_comb begin
         y_d   = y_q;
         cnt_d = cnt_q;
         busy  = '0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (raw[c] == y_q[c]) begin
               cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_MAX) begin
               y_d[c]   = raw[c];
               cnt_d[c] = '0;
            end else begin
               cnt_d[c] = cnt_q[c] + CW'(1);
            end
            busy[c] = (cnt_q[c] != '0);
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            y_q   <= '1;
            cnt_q <= '0;
         end else begin
            y_q   <= y_d;
            cnt_q <= cnt_d;
         end
      end

      assign y = y_q;
   end

endmodule

// File: tb/tb_nand_gate_array_cycle_delay.sv
// Bench for nand_gate_array_cycle_delay: transport and inertial instances
// (DELAY_CYC=3) plus an inertial DELAY_CYC=1 instance, all on one input bus.
module tb_nand_gate_array_cycle_delay;

   logic        clk;
   logic        clk_en;
   logic        rst;
   logic [31:0] in_bus;
   logic [3:0]  y_t, busy_t, y_i, busy_i, y_1, busy_1;

   int checks;
   int errors;
   bit mdl_en;

   nand_gate_array_cycle_delay #(.CHANNELS(4), .INPUTS(8), .DELAY_CYC(3), .INERTIAL(0)) dut_t (
      .clk(clk), .rst(rst), .in_bus(in_bus), .y(y_t), .busy(busy_t));
   nand_gate_array_cycle_delay #(.CHANNELS(4), .INPUTS(8), .DELAY_CYC(3), .INERTIAL(1)) dut_i (
      .clk(clk), .rst(rst), .in_bus(in_bus), .y(y_i), .busy(busy_i));
   nand_gate_array_cycle_delay #(.CHANNELS(4), .INPUTS(8), .DELAY_CYC(1), .INERTIAL(1)) dut_1 (
      .clk(clk), .rst(rst), .in_bus(in_bus), .y(y_1), .busy(busy_1));

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Transport: y is the raw vector sampled DELAY edges ago (history of the last 3 samples).
   // Inertial: y flips once a mismatch has persisted for D edges since the last anchor
   // edge (last edge where raw matched y, or where y flipped).
   logic [3:0] thist[$];
   int         edge_n;
   int         anc_i[4];
   int         anc_1[4];
   logic [3:0] yi_m, y1_m;

   function automatic logic [3:0] raw_of(input logic [31:0] b);
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = ~&b[c*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      thist = {};
      for (int k = 0; k < 3; k++) thist.push_back(4'hF);
      edge_n = 0;
      yi_m   = 4'hF;
      y1_m   = 4'hF;
      for (int c = 0; c < 4; c++) begin
         anc_i[c] = 0;
         anc_1[c] = 0;
      end
   endtask

   task automatic model_edge();
      logic [3:0] r;
      r = raw_of(in_bus);
      thist.push_back(r);
      void'(thist.pop_front());
      edge_n++;
      for (int c = 0; c < 4; c++) begin
         if (r[c] == yi_m[c]) anc_i[c] = edge_n;
         else if (edge_n - anc_i[c] == 3) begin
            yi_m[c]  = r[c];
            anc_i[c] = edge_n;
         end
         if (r[c] == y1_m[c]) anc_1[c] = edge_n;
         else if (edge_n - anc_1[c] == 1) begin
            y1_m[c]  = r[c];
            anc_1[c] = edge_n;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: act=%0h req=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [3:0] bt, bi, b1;
      bt = '0;
      for (int k = 1; k < 3; k++) bt = bt | (thist[k] ^ thist[0]);
      for (int c = 0; c < 4; c++) begin
         bi[c] = (anc_i[c] != edge_n);
         b1[c] = (anc_1[c] != edge_n);
      end
      chk("model y_t", 32'(y_t), 32'(thist[0]));
      chk("model busy_t", 32'(busy_t), 32'(bt));
      chk("model y_i", 32'(y_i), 32'(yi_m));
      chk("model busy_i", 32'(busy_i), 32'(bi));
      chk("model y_1", 32'(y_1), 32'(y1_m));
      chk("model busy_1", 32'(busy_1), 32'(b1));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      @(negedge clk);
      if (mdl_en) model_check();
   endtask

   task automatic settle_zero();
      in_bus = '0;
      repeat (4) step();
   endtask

   typedef struct {
      logic [31:0] bus;
      logic [3:0]  exp_y;
   } vec_t;

   vec_t tbl[$];

   initial begin
      vec_t       v;
      logic [7:0] chv;
      checks = 0;
      errors = 0;
      mdl_en = 1'b0;
      clk_en = 1'b0;
      rst    = 1'b0;
      in_bus = '1;

      // table: each single input low -> 1; all inputs high -> 0; sweep channels
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 8; k++) begin
            chv       = 8'hFF;
            chv[k]    = 1'b0;
            v.bus     = '0;
            v.bus[c*8 +: 8] = chv;
            v.exp_y   = 4'hF;
            tbl.push_back(v);
         end
         v.bus     = '0;
         v.bus[c*8 +: 8] = 8'hFF;
         v.exp_y   = 4'hF;
         v.exp_y[c] = 1'b0;
         tbl.push_back(v);
      end
      v.bus   = '1;
      v.exp_y = 4'h0;
      tbl.push_back(v);

      // 1: asynchronous reset with no clock running
      #3 rst = 1'b1;
      model_reset();
      #2;
      chk("rst y_t", 32'(y_t), 32'hF);
      chk("rst busy_t", 32'(busy_t), 32'h0);
      chk("rst y_i", 32'(y_i), 32'hF);
      chk("rst busy_i", 32'(busy_i), 32'h0);
      chk("rst y_1", 32'(y_1), 32'hF);
      chk("rst busy_1", 32'(busy_1), 32'h0);
      mdl_en = 1'b1;
      clk_en = 1'b1;
      step();
      step();
      rst = 1'b0;
      settle_zero();

      // 2: transport steady change and 1-cycle pulse on ch0
      in_bus[7:0] = 8'hFF;
      for (int e = 0; e < 3; e++) begin
         step();
         chk("tr y0", 32'(y_t[0]), (e == 2) ? 32'h0 : 32'h1);
         chk("tr busy0", 32'(busy_t[0]), (e == 2) ? 32'h0 : 32'h1);
      end
      settle_zero();
      in_bus[7:0] = 8'hFF;
      for (int e = 0; e < 4; e++) begin
         step();
         in_bus[7:0] = 8'h00;
         chk("tr pulse y0", 32'(y_t[0]), (e == 2) ? 32'h0 : 32'h1);
         chk("tr pulse busy0", 32'(busy_t[0]), (e == 3) ? 32'h0 : 32'h1);
      end

      // 3: inertial short mismatch swallowed, long mismatch passed
      settle_zero();
      in_bus[7:0] = 8'hFF;
      step();
      chk("in short y0 e0", 32'(y_i[0]), 32'h1);
      chk("in short busy0 e0", 32'(busy_i[0]), 32'h1);
      step();
      chk("in short busy0 e1", 32'(busy_i[0]), 32'h1);
      in_bus[7:0] = 8'hFE;
      step();
      chk("in short y0 e2", 32'(y_i[0]), 32'h1);
      chk("in short busy0 e2", 32'(busy_i[0]), 32'h0);
      in_bus[7:0] = 8'hFF;
      for (int e = 0; e < 3; e++) begin
         step();
         chk("in long y0", 32'(y_i[0]), (e == 2) ? 32'h0 : 32'h1);
         chk("in long busy0", 32'(busy_i[0]), (e == 2) ? 32'h0 : 32'h1);
      end

      // 4: independence, ch1 steady change while ch2 toggles every cycle
      settle_zero();
      in_bus[15:8] = 8'hFF;
      for (int e = 0; e < 6; e++) begin
         in_bus[23:16] = (e % 2 == 0) ? 8'hFF : 8'h00;
         step();
         chk("ind y_i2", 32'(y_i[2]), 32'h1);
         chk("ind busy_i2", 32'(busy_i[2]), (e % 2 == 0) ? 32'h1 : 32'h0);
         chk("ind y_t1", 32'(y_t[1]), (e < 2) ? 32'h1 : 32'h0);
         chk("ind y_i1", 32'(y_i[1]), (e < 2) ? 32'h1 : 32'h0);
      end

      // 5: reset while inertial ch0 count is 2, then count restarts
      settle_zero();
      in_bus[7:0] = 8'hFF;
      step();
      step();
      chk("mid busy_i0", 32'(busy_i[0]), 32'h1);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("mid rst y_i", 32'(y_i), 32'hF);
      chk("mid rst busy_i", 32'(busy_i), 32'h0);
      chk("mid rst y_t", 32'(y_t), 32'hF);
      chk("mid rst busy_t", 32'(busy_t), 32'h0);
      #1 rst = 1'b0;
      for (int e = 0; e < 3; e++) begin
         step();
         chk("mid y_i0", 32'(y_i[0]), (e == 2) ? 32'h0 : 32'h1);
         chk("mid busy_i0 after", 32'(busy_i[0]), (e == 2) ? 32'h0 : 32'h1);
      end

      // 6: table sweep
      foreach (tbl[i]) begin
         in_bus = tbl[i].bus;
         repeat (3) step();
         chk("tbl y_t", 32'(y_t), 32'(tbl[i].exp_y));
         chk("tbl y_i", 32'(y_i), 32'(tbl[i].exp_y));
         chk("tbl y_1", 32'(y_1), 32'(tbl[i].exp_y));
         chk("tbl busy", 32'({busy_t, busy_i, busy_1}), 32'h0);
      end

      // randomized traffic against the model, with occasional resets
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < 4; c++) begin
            case ($urandom_range(3))
               0, 1: in_bus[c*8 +: 8] = 8'hFF;
               2: begin
                  chv = 8'hFF;
                  chv[$urandom_range(7)] = 1'b0;
                  in_bus[c*8 +: 8] = chv;
               end
               default: in_bus[c*8 +: 8] = 8'($urandom);
            endcase
         end
         if ($urandom_range(59) == 0) begin
            rst = 1'b1;
            model_reset();
            step();
            rst = 1'b0;
         end else begin
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
